// File: rtl/ram64x12_fifo_ctrl_pkg.sv
// Shared constants and types for the 64x12 RAM-backed FIFO controller.
// RAM static tie-offs are applied by the integrating wrapper.
package ram64x12_fifo_ctrl_pkg;

   localparam int unsigned DEPTH = 64;
   localparam int unsigned AW    = 6;
   localparam int unsigned DW    = 12;
   localparam int unsigned CW    = AW + 1;

   // Unregistered read address, registered read data: one-cycle read latency.
   localparam logic RAM_R_ADDR_BYPASS = 1'b1;
   localparam logic RAM_R_DATA_BYPASS = 1'b0;
   localparam logic RAM_W_ADDR_BYPASS = 1'b1;
   localparam logic RAM_SL_N          = 1'b1;
   localparam logic RAM_AL_N          = 1'b1;
   localparam logic RAM_SD            = 1'b0;
   localparam logic RAM_AD_N          = 1'b1;

   typedef logic [DW-1:0] word_t;
   typedef logic [AW-1:0] addr_t;
   typedef logic [AW:0]   ptr_t;
   typedef logic [CW-1:0] count_t;

endpackage

// File: rtl/ram64x12_fifo_ctrl_if.sv
// Stream and RAM-port bundle for ram64x12_fifo_ctrl.
// slave is the controller's view; master is the producer/consumer/RAM side.
interface ram64x12_fifo_ctrl_if;
   import ram64x12_fifo_ctrl_pkg::*;

   logic   in_valid;
   logic   in_ready;
   word_t  in_data;
   logic   out_valid;
   logic   out_ready;
   word_t  out_data;
   count_t count;
   addr_t  ram_w_addr;
   word_t  ram_w_data;
   logic   ram_w_en;
   addr_t  ram_r_addr;
   logic   ram_r_data_en;
   logic   ram_blk_en;
   word_t  ram_r_data;
   logic   ram_access_busy;

   modport slave (
      input  in_valid, in_data, out_ready, ram_r_data, ram_access_busy,
      output in_ready, out_valid, out_data, count,
      output ram_w_addr, ram_w_data, ram_w_en, ram_r_addr, ram_r_data_en, ram_blk_en
   );

   modport master (
      output in_valid, in_data, out_ready, ram_r_data, ram_access_busy,
      input  in_ready, out_valid, out_data, count,
      input  ram_w_addr, ram_w_data, ram_w_en, ram_r_addr, ram_r_data_en, ram_blk_en
   );

endinterface

// File: rtl/ram64x12_fifo_obuf.sv
// Two-entry output buffer; entry 0 is the head and keeps its value once drained.
module ram64x12_fifo_obuf
   import ram64x12_fifo_ctrl_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       push,
   input  word_t      push_data,
   input  logic       pop,
   output word_t      head,
   output logic       valid,
   output logic [1:0] count
);

   word_t      data0_q, data0_d, data1_q, data1_d;
   logic [1:0] cnt_q, cnt_d;
   logic       pop_ok;

   always_comb begin
      data0_d = data0_q;
      data1_d = data1_q;
      cnt_d   = cnt_q;
      pop_ok  = pop & (cnt_q != 2'd0);
      case (cnt_q)
         2'd0: begin
            if (push) begin
               data0_d = push_data;
               cnt_d   = 2'd1;
            end
         end
         2'd1: begin
            if (push && pop_ok) begin
               data0_d = push_data;
            end else if (push) begin
               data1_d = push_data;
               cnt_d   = 2'd2;
            end else if (pop_ok) begin
               cnt_d = 2'd0;
            end
         end
         2'd2: begin
            // The controller never pushes into a full buffer without a pop.
            if (pop_ok) begin
               data0_d = data1_q;
               if (push) begin
                  data1_d = push_data;
               end else begin
                  cnt_d = 2'd1;
               end
            end
         end
         default: cnt_d = cnt_q;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data0_q <= '0;
         data1_q <= '0;
         cnt_q   <= 2'd0;
      end else begin
         data0_q <= data0_d;
         data1_q <= data1_d;
         cnt_q   <= cnt_d;
      end
   end

   assign head  = data0_q;
   assign valid = (cnt_q != 2'd0);
   assign count = cnt_q;

endmodule

// File: rtl/ram64x12_fifo_ctrl.sv
// FIFO controller over an external 64x12 RAM with a 2-entry prefetch output buffer.
// Reads are issued ahead so the buffer hides the RAM's one-cycle read latency.
module ram64x12_fifo_ctrl
   import ram64x12_fifo_ctrl_pkg::*;
(
   input logic                 clk,
   input logic                 rst_n,
   ram64x12_fifo_ctrl_if.slave bus
);

   localparam count_t FULL_COUNT = count_t'(DEPTH);

   ptr_t       wr_ptr_q, wr_ptr_d;
   ptr_t       rd_ptr_q, rd_ptr_d;
   logic       inflight_q;
   logic       ready_en_q;
   count_t     ram_occ;
   count_t     total;
   logic [1:0] buf_cnt;
   logic [1:0] pending;
   logic       in_ready;
   logic       push;
   logic       issue;
   logic       pop;
   logic       buf_valid;
   word_t      buf_head;

   always_comb begin
      ram_occ  = wr_ptr_q - rd_ptr_q;
      pending  = buf_cnt + {1'b0, inflight_q};
      total    = ram_occ + count_t'(pending);
      // ready_en_q holds IN_READY low until the first edge after reset release.
      in_ready = ready_en_q & (total < FULL_COUNT) & ~bus.ram_access_busy;
      push     = bus.in_valid & in_ready;
      issue    = (ram_occ != '0) & (pending < 2'd2) & ~bus.ram_access_busy;
      pop      = buf_valid & bus.out_ready;
      wr_ptr_d = push  ? wr_ptr_q + ptr_t'(1) : wr_ptr_q;
      rd_ptr_d = issue ? rd_ptr_q + ptr_t'(1) : rd_ptr_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         inflight_q <= 1'b0;
         ready_en_q <= 1'b0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         inflight_q <= issue;
         ready_en_q <= 1'b1;
      end
   end

   ram64x12_fifo_obuf u_obuf (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (inflight_q),
      .push_data (bus.ram_r_data),
      .pop       (pop),
      .head      (buf_head),
      .valid     (buf_valid),
      .count     (buf_cnt)
   );

   assign bus.in_ready      = in_ready;
   assign bus.out_valid     = buf_valid;
   assign bus.out_data      = buf_head;
   assign bus.count         = total;
   assign bus.ram_w_en      = push;
   assign bus.ram_w_addr    = wr_ptr_q[AW-1:0];
   assign bus.ram_w_data    = bus.in_data;
   assign bus.ram_r_data_en = issue;
   assign bus.ram_blk_en    = issue;
   assign bus.ram_r_addr    = rd_ptr_q[AW-1:0];

endmodule

// File: tb/tb_ram64x12_fifo_ctrl.sv
// Bench for ram64x12_fifo_ctrl: behavioural RAM plus a queue-based FIFO reference.
module tb_ram64x12_fifo_ctrl;
   import ram64x12_fifo_ctrl_pkg::*;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   ram64x12_fifo_ctrl_if bus ();

   ram64x12_fifo_ctrl dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   // Behavioural RAM: registered read data, valid one cycle after the enable.
   logic [11:0] ram_mem [64];
   always @(posedge clk) begin
      if (bus.ram_w_en === 1'b1) ram_mem[bus.ram_w_addr] <= bus.ram_w_data;
      if (bus.ram_r_data_en === 1'b1) bus.ram_r_data <= ram_mem[bus.ram_r_addr];
   end

   int          n_cmp = 0;
   int          n_bad = 0;
   logic [11:0] q [$];
   int          wr_total = 0;
   int          rd_total = 0;
   int          popped = 0;
   bit          ready_ok = 1'b0;
   logic        obs_valid, obs_ready, obs_push;
   logic [11:0] obs_data;
   logic [6:0]  obs_count;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
      $fatal(1, "watchdog");
   end

   // One clock: drive before the edge, sample at #1, check invariants, update reference.
   task automatic cycle(input logic iv, input logic [11:0] id, input logic ordy,
                        input logic busy);
      logic        exp_ready, exp_push, do_pop, r_en;
      logic [11:0] want;
      int          occ;
      @(negedge clk);
      bus.in_valid        = iv;
      bus.in_data         = id;
      bus.out_ready       = ordy;
      bus.ram_access_busy = busy;
      #1;
      exp_ready = ready_ok && (q.size() < 64) && !busy;
      exp_push  = iv && exp_ready;
      occ       = wr_total - rd_total;
      want      = (q.size() > 0) ? q[0] : 12'h000;
      n_cmp++;
      if (bus.count !== 7'(q.size())) begin
         n_bad++;
         $display("FAIL count: got %0d, want %0d", bus.count, q.size());
      end
      n_cmp++;
      if (bus.in_ready !== exp_ready) begin
         n_bad++;
         $display("FAIL in_ready: got %b, want %b", bus.in_ready, exp_ready);
      end
      n_cmp++;
      if (bus.ram_w_en !== exp_push) begin
         n_bad++;
         $display("FAIL ram_w_en: got %b, want %b", bus.ram_w_en, exp_push);
      end
      if (exp_push) begin
         n_cmp++;
         if (bus.ram_w_addr !== 6'(wr_total) || bus.ram_w_data !== id) begin
            n_bad++;
            $display("FAIL w_port: got addr %0d data %h, want addr %0d data %h",
                     bus.ram_w_addr, bus.ram_w_data, wr_total % 64, id);
         end
      end
      n_cmp++;
      if (bus.ram_blk_en !== bus.ram_r_data_en) begin
         n_bad++;
         $display("FAIL blk_en: got %b, want %b (r_data_en)", bus.ram_blk_en,
                  bus.ram_r_data_en);
      end
      r_en = (bus.ram_r_data_en === 1'b1);
      if (r_en) begin
         n_cmp++;
         if (busy || occ < 1 || bus.ram_r_addr !== 6'(rd_total) ||
             (bus.ram_w_en === 1'b1 && bus.ram_w_addr == bus.ram_r_addr)) begin
            n_bad++;
            $display("FAIL r_issue: got addr %0d busy %b occ %0d w_en %b w_addr %0d, want addr %0d",
                     bus.ram_r_addr, busy, occ, bus.ram_w_en, bus.ram_w_addr, rd_total % 64);
         end
      end
      if (bus.out_valid === 1'b1) begin
         n_cmp++;
         if (q.size() == 0 || bus.out_data !== want) begin
            n_bad++;
            $display("FAIL head: got %h (held %0d), want %h", bus.out_data, q.size(), want);
         end
      end
      obs_valid = bus.out_valid;
      obs_ready = bus.in_ready;
      obs_data  = bus.out_data;
      obs_count = bus.count;
      obs_push  = exp_push;
      do_pop    = (bus.out_valid === 1'b1) && ordy && (q.size() > 0);
      @(posedge clk);
      if (exp_push) begin
         q.push_back(id);
         wr_total++;
      end
      if (do_pop) begin
         void'(q.pop_front());
         popped++;
      end
      if (r_en) rd_total++;
   endtask

   task automatic drain(input string name);
      int guard = 0;
      while (q.size() > 0 && guard < 400) begin
         cycle(1'b0, 12'h000, 1'b1, 1'b0);
         guard++;
      end
      n_cmp++;
      if (q.size() != 0) begin
         n_bad++;
         $display("FAIL %s_drain: got %0d words left, want 0", name, q.size());
      end
   endtask

   task automatic test_reset();
      repeat (2) @(negedge clk);
      #1;
      n_cmp++;
      if (bus.count !== 7'd0 || bus.out_valid !== 1'b0 || bus.out_data !== 12'h000) begin
         n_bad++;
         $display("FAIL reset_out: got count %0d valid %b data %h, want 0 0 000",
                  bus.count, bus.out_valid, bus.out_data);
      end
      n_cmp++;
      if (bus.in_ready !== 1'b0 || bus.ram_w_en !== 1'b0 || bus.ram_r_data_en !== 1'b0 ||
          bus.ram_blk_en !== 1'b0) begin
         n_bad++;
         $display("FAIL reset_strobes: got rdy %b w %b r %b blk %b, want all 0",
                  bus.in_ready, bus.ram_w_en, bus.ram_r_data_en, bus.ram_blk_en);
      end
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      n_cmp++;
      if (bus.in_ready !== 1'b0) begin
         n_bad++;
         $display("FAIL ready_before_edge: got %b, want 0", bus.in_ready);
      end
      @(posedge clk);
      ready_ok = 1'b1;
      #1;
      n_cmp++;
      if (bus.in_ready !== 1'b1) begin
         n_bad++;
         $display("FAIL ready_after_edge: got %b, want 1", bus.in_ready);
      end
   endtask

   task automatic test_latency();
      logic v [5];
      logic [11:0] d [5];
      cycle(1'b1, 12'h001, 1'b1, 1'b0);
      v[0] = obs_valid;
      d[0] = obs_data;
      for (int i = 1; i < 5; i++) begin
         cycle(1'b0, 12'h000, 1'b1, 1'b0);
         v[i] = obs_valid;
         d[i] = obs_data;
      end
      n_cmp++;
      if (v[0] !== 1'b0 || v[1] !== 1'b0 || v[2] !== 1'b0) begin
         n_bad++;
         $display("FAIL latency_early: got valid %b%b%b, want 000", v[0], v[1], v[2]);
      end
      n_cmp++;
      if (v[3] !== 1'b1 || d[3] !== 12'h001) begin
         n_bad++;
         $display("FAIL latency_head: got valid %b data %h, want 1 001", v[3], d[3]);
      end
      n_cmp++;
      if (v[4] !== 1'b0 || d[4] !== 12'h001) begin
         n_bad++;
         $display("FAIL empty_hold: got valid %b data %h, want 0 001", v[4], d[4]);
      end
   endtask

   task automatic test_fill_and_swap();
      int p0 = popped;
      for (int i = 0; i < 64; i++) cycle(1'b1, 12'(i), 1'b0, 1'b0);
      cycle(1'b1, 12'h040, 1'b0, 1'b0);
      n_cmp++;
      if (obs_ready !== 1'b0 || obs_count !== 7'd64 || obs_push !== 1'b0) begin
         n_bad++;
         $display("FAIL full: got ready %b count %0d, want 0 64", obs_ready, obs_count);
      end
      cycle(1'b1, 12'h7AA, 1'b1, 1'b0);
      n_cmp++;
      if (obs_valid !== 1'b1 || obs_data !== 12'h000 || obs_ready !== 1'b0) begin
         n_bad++;
         $display("FAIL swap: got valid %b data %h ready %b, want 1 000 0",
                  obs_valid, obs_data, obs_ready);
      end
      cycle(1'b0, 12'h000, 1'b0, 1'b0);
      n_cmp++;
      if (obs_ready !== 1'b1 || obs_count !== 7'd63) begin
         n_bad++;
         $display("FAIL after_swap: got ready %b count %0d, want 1 63", obs_ready, obs_count);
      end
      drain("fill");
      n_cmp++;
      if (popped - p0 != 64) begin
         n_bad++;
         $display("FAIL fill_pops: got %0d, want 64", popped - p0);
      end
   endtask

   task automatic test_stream();
      int sent = 0;
      int p0 = popped;
      int guard = 0;
      logic iv;
      while ((sent < 200 || q.size() > 0) && guard < 3000) begin
         iv = (sent < 200) && ($urandom_range(3) != 0);
         cycle(iv, 12'($urandom), $urandom_range(2) != 0, 1'b0);
         if (obs_push) sent++;
         guard++;
      end
      n_cmp++;
      if (popped - p0 != 200 || sent != 200) begin
         n_bad++;
         $display("FAIL stream: got sent %0d popped %0d, want 200 200", sent, popped - p0);
      end
   endtask

   task automatic test_busy();
      int p0 = popped;
      int pb;
      for (int i = 0; i < 10; i++) cycle(1'b1, 12'(12'h100 + i), 1'b0, 1'b0);
      repeat (5) cycle(1'b0, 12'h000, 1'b0, 1'b0);
      pb = popped;
      repeat (5) cycle(1'b1, 12'h200, 1'b1, 1'b1);
      n_cmp++;
      if (popped - pb != 2) begin
         n_bad++;
         $display("FAIL busy_drain: got %0d pops while busy, want 2", popped - pb);
      end
      drain("busy");
      n_cmp++;
      if (popped - p0 != 10) begin
         n_bad++;
         $display("FAIL busy_total: got %0d, want 10", popped - p0);
      end
   endtask

   task automatic test_reset_mid();
      for (int i = 0; i < 10; i++) cycle(1'b1, 12'(12'h300 + i), 1'b0, 1'b0);
      cycle(1'b0, 12'h000, 1'b0, 1'b0);
      n_cmp++;
      if (obs_count !== 7'd10) begin
         n_bad++;
         $display("FAIL pre_reset: got count %0d, want 10", obs_count);
      end
      @(negedge clk);
      bus.in_valid = 1'b1;
      #2;
      rst_n = 1'b0;
      #1;
      n_cmp++;
      if (bus.count !== 7'd0 || bus.out_valid !== 1'b0 || bus.out_data !== 12'h000 ||
          bus.in_ready !== 1'b0) begin
         n_bad++;
         $display("FAIL async_reset: got count %0d valid %b data %h ready %b, want 0 0 000 0",
                  bus.count, bus.out_valid, bus.out_data, bus.in_ready);
      end
      n_cmp++;
      if (bus.ram_w_en !== 1'b0 || bus.ram_r_data_en !== 1'b0 || bus.ram_blk_en !== 1'b0) begin
         n_bad++;
         $display("FAIL async_strobes: got w %b r %b blk %b, want 000",
                  bus.ram_w_en, bus.ram_r_data_en, bus.ram_blk_en);
      end
      q.delete();
      wr_total = 0;
      rd_total = 0;
      ready_ok = 1'b0;
      repeat (2) @(negedge clk);
      bus.in_valid = 1'b0;
      rst_n = 1'b1;
      @(posedge clk);
      ready_ok = 1'b1;
      cycle(1'b0, 12'h000, 1'b1, 1'b0);
      n_cmp++;
      if (obs_count !== 7'd0 || obs_valid !== 1'b0 || obs_ready !== 1'b1) begin
         n_bad++;
         $display("FAIL post_reset: got count %0d valid %b ready %b, want 0 0 1",
                  obs_count, obs_valid, obs_ready);
      end
   endtask

   initial begin
      bus.in_valid        = 1'b0;
      bus.in_data         = 12'h000;
      bus.out_ready       = 1'b0;
      bus.ram_access_busy = 1'b0;
      test_reset();
      test_latency();
      test_fill_and_swap();
      test_stream();
      test_busy();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/ram64x12_fifo_ctrl.md
RAM64X12_FIFO_CTRL -- requirements
Module: ram64x12_fifo_ctrl

Interface
REQ-001 Parameter: none; depth fixed at 64 words, width fixed at 12 bits.
REQ-002 Clock and reset: one clock, CLK; reset is asynchronous and active-low, RST_N.
REQ-003 CLK  in  1  single clock; drives RAM R_CLK and W_CLK at integration.
REQ-004 RST_N  in  1  asynchronous active-low reset.
REQ-005 IN_VALID  in  1  push request.
REQ-006 IN_READY  out  1  push accepted when IN_VALID&IN_READY at rising CLK.
REQ-007 IN_DATA  in  12  push word.
REQ-008 OUT_VALID  out  1  OUT_DATA holds the oldest word.
REQ-009 OUT_READY  in  1  pop when OUT_VALID&OUT_READY at rising CLK.
REQ-010 OUT_DATA  out  12  head word.
REQ-011 COUNT  out  7  total words held, 0..64.
REQ-012 RAM_W_ADDR  out  6; RAM_W_DATA  out  12; RAM_W_EN  out  1 -- RAM write port.
REQ-013 RAM_R_ADDR  out  6; RAM_R_DATA_EN  out  1; RAM_BLK_EN  out  1 -- RAM read port.
REQ-014 RAM_R_DATA  in  12 -- RAM read data; RAM_ACCESS_BUSY  in  1 -- RAM busy.

Function
REQ-015 RAM configuration: R_ADDR_BYPASS=1 (unregistered address), R_DATA_BYPASS=0 (registered data); read data valid exactly 1 cycle after RAM_R_DATA_EN is sampled high.
REQ-016 Write: on accepted push, RAM_W_EN=1, RAM_W_ADDR=wr_ptr[5:0], RAM_W_DATA=IN_DATA, all combinational in the push cycle; wr_ptr increments at that edge.
REQ-017 Pointers wr_ptr, rd_ptr 7 bits; wrap 63->0 on low 6 bits; RAM occupancy = wr_ptr - rd_ptr modulo 128.
REQ-018 Output buffer: 2-entry FIFO of 12-bit words; head drives OUT_DATA; OUT_VALID = buffer non-empty.
REQ-019 Read issue condition: RAM occupancy (registered pointers) >= 1, buffer entries + in-flight reads < 2, RAM_ACCESS_BUSY=0.
REQ-020 On issue: RAM_R_DATA_EN=1, RAM_BLK_EN=1, RAM_R_ADDR=rd_ptr[5:0]; rd_ptr increments; in-flight flag set; next cycle RAM_R_DATA written to buffer.
REQ-021 Same-cycle write and read of one address is impossible by REQ-019; a word pushed at edge N is readable no earlier than cycle N+1.
REQ-022 Latency: empty FIFO, push accepted at edge 0 -> OUT_VALID=1 after edge 2 with that word.
REQ-023 COUNT = RAM occupancy + in-flight + buffer entries; IN_READY = (COUNT < 64) & ~RAM_ACCESS_BUSY.
REQ-024 Full (COUNT=64): IN_READY=0; simultaneous pop restores IN_READY next cycle, not same cycle.
REQ-025 Empty: OUT_VALID=0, OUT_DATA holds last value; OUT_READY ignored.
REQ-026 Simultaneous push and pop: both take effect; COUNT unchanged.
REQ-027 RAM_ACCESS_BUSY=1: no write, no read issue; in-flight data still captured; buffer still drains.
REQ-028 RAM_W_EN, RAM_R_DATA_EN, RAM_BLK_EN low in all cycles without a qualifying event.

Reset
REQ-029 RST_N low asynchronously clears wr_ptr, rd_ptr, in-flight flag, buffer; COUNT=0, OUT_VALID=0, OUT_DATA=0, IN_READY=0, all RAM strobes 0.
REQ-030 IN_READY rises on the first CLK edge after RST_N deasserts; reset mid-operation discards all content, RAM contents not cleared.
REQ-031 RST_N deassertion is synchronized externally; no internal synchronizer.

Structure
REQ-032 Shared package holds DEPTH=64, AW=6, DW=12, and RAM static tie-off constants (bypass, SL_N/AL_N=1, SD/AD_N values).
REQ-033 One sub-module: ram64x12_fifo_obuf (2-entry output buffer with push/pop/count).
REQ-034 RAM64x12 instance and tie-offs live in the integrating wrapper, not in this block.

Verification
REQ-035 Bench uses a behavioural RAM64x12 model honouring REQ-015.
REQ-036 Push 0x001 into empty, OUT_READY=1 -> OUT_VALID high two cycles after push, OUT_DATA=0x001, COUNT 1 then 0.
REQ-037 Push 64 words 0x000..0x03F with OUT_READY=0 -> IN_READY=0 at COUNT=64; 65th push refused; pop yields 0x000..0x03F in order.
REQ-038 Full FIFO, push and pop same cycle -> pop accepted, push refused, IN_READY=1 next cycle, COUNT=63.
REQ-039 Streaming 200 words with random IN_VALID/OUT_READY -> in-order output, pointer wrap verified, no RAM write/read same address same cycle.
REQ-040 RAM_ACCESS_BUSY high 5 cycles mid-stream -> no RAM strobes, IN_READY=0, buffered words still pop; resume without loss.
REQ-041 RST_N low with COUNT=10 -> outputs per REQ-029 immediately; after release COUNT=0, OUT_VALID=0.
